// File: rtl/alu_pkg.sv
// Shared ALU definitions: Op encodings, Op width and the sequencer state enum.
package alu_pkg;

    localparam int OP_W = 3;

    // ALU Op encodings (OP_ADD is the plain A+B passthrough used by multiply)
    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Command/response sequencer in front of the ALU. Runs single ALU ops in one
// cycle, or an unsigned shift-add multiply that reuses the ALU adder once per
// multiplier bit. The ALU itself lives outside and is reached via i_/o_alu_*.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_mul,
    input  logic [OP_W-1:0]      i_cmd_op,
    input  logic [WIDTH-1:0]     i_cmd_a,
    input  logic [WIDTH-1:0]     i_cmd_b,
    output logic [OP_W-1:0]      o_alu_op,
    output logic [WIDTH-1:0]     o_alu_a,
    output logic [WIDTH-1:0]     o_alu_b,
    input  logic [WIDTH-1:0]     i_alu_r,
    input  logic                 i_alu_c,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [2*WIDTH-1:0]   o_rsp_data,
    output logic                 o_rsp_carry
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    seq_state_e          r_state;
    seq_state_e          w_state_nxt;
    logic [OP_W-1:0]     r_op;
    logic [WIDTH-1:0]    r_md;       // multiplicand / operand A
    logic [WIDTH-1:0]    r_mq;       // multiplier-quotient / operand B
    logic [WIDTH-1:0]    r_acc;      // upper half of the running product
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_rsp_data;
    logic                r_rsp_carry;

    logic                w_accept;
    logic                w_mul_last;
    logic [WIDTH-1:0]    w_acc_nxt;
    logic [WIDTH-1:0]    w_mq_nxt;

    assign w_accept   = i_cmd_valid & o_cmd_ready;
    assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));
    // Shift {carry, sum, mq} right by one: the adder carry lands in acc's MSB
    assign w_acc_nxt  = {i_alu_c, i_alu_r[WIDTH-1:1]};
    assign w_mq_nxt   = {i_alu_r[0], r_mq[WIDTH-1:1]};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = i_cmd_mul ? S_MUL : S_EXEC;
            S_EXEC: w_state_nxt = S_DONE;
            S_MUL:  if (w_mul_last) w_state_nxt = S_DONE;
            S_DONE: if (i_rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs: handshakes from state; ALU inputs held quiet outside EXEC/MUL
    always_comb begin
        o_cmd_ready = (r_state == S_IDLE);
        o_rsp_valid = (r_state == S_DONE);
        o_alu_op    = OP_ADD;
        o_alu_a     = '0;
        o_alu_b     = '0;
        case (r_state)
            S_EXEC: begin
                o_alu_op = r_op;
                o_alu_a  = r_md;
                o_alu_b  = r_mq;
            end
            S_MUL: begin
                o_alu_op = OP_ADD;
                o_alu_a  = r_acc;
                o_alu_b  = r_mq[0] ? r_md : '0;
            end
            default: ;
        endcase
    end

    // Operand latch, multiply iteration and response capture
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op        <= '0;
            r_md        <= '0;
            r_mq        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op  <= i_cmd_op;
                    r_md  <= i_cmd_a;
                    r_mq  <= i_cmd_b;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                S_EXEC: begin
                    r_rsp_data  <= {{WIDTH{1'b0}}, i_alu_r};
                    r_rsp_carry <= i_alu_c;
                end
                S_MUL: begin
                    r_acc <= w_acc_nxt;
                    r_mq  <= w_mq_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_rsp_data  <= {w_acc_nxt, w_mq_nxt};
                        r_rsp_carry <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_carry = r_rsp_carry;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural ALU on the alu_* ports.
module tb_alu_seq_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready;
    logic       i_cmd_mul = 1'b0;
    logic [2:0] i_cmd_op = 3'b000;
    logic [3:0] i_cmd_a = 4'h0;
    logic [3:0] i_cmd_b = 4'h0;
    logic [2:0] o_alu_op;
    logic [3:0] o_alu_a;
    logic [3:0] o_alu_b;
    logic [3:0] i_alu_r;
    logic       i_alu_c;
    logic       o_rsp_valid;
    logic       i_rsp_ready = 1'b1;
    logic [7:0] o_rsp_data;
    logic       o_rsp_carry;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    alu_seq_ctrl #(.WIDTH(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_mul(i_cmd_mul), .i_cmd_op(i_cmd_op),
        .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
        .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_r(i_alu_r), .i_alu_c(i_alu_c),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_carry(o_rsp_carry)
    );

    // Behavioural ALU: ADD, SUB (a + ~b + 1), AND, OR, XOR
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = 5'd0;
        case (o_alu_op)
            3'b000: alu_sum = {1'b0, o_alu_a} + {1'b0, o_alu_b};
            3'b001: alu_sum = {1'b0, o_alu_a} + {1'b0, ~o_alu_b} + 5'd1;
            3'b010: alu_sum = {1'b0, o_alu_a & o_alu_b};
            3'b011: alu_sum = {1'b0, o_alu_a | o_alu_b};
            3'b100: alu_sum = {1'b0, o_alu_a ^ o_alu_b};
            default: alu_sum = 5'd0;
        endcase
    end
    assign i_alu_r = alu_sum[3:0];
    assign i_alu_c = alu_sum[4];

    typedef struct {
        logic       mul;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] data;
        logic       carry;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];
    int   acc_c[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present one command at the negedge; return #1 after the accepting edge
    task automatic send(input logic mul, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge i_clk);
        i_cmd_mul = mul; i_cmd_op = op; i_cmd_a = a; i_cmd_b = b;
        i_cmd_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    // Count edges after acceptance until rsp_valid; also count cycles with alu_b==F
    task automatic wait_rsp(output int edges, output int nbf);
        edges = 0;
        nbf = 0;
        while (!o_rsp_valid && edges < 20) begin
            if (o_alu_b == 4'hF) nbf++;
            @(posedge i_clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        int edges, nbf, seen, idx, got, cyc;
        bit acc;
        logic [2:0] bop[3];
        logic       bmul[3];
        logic [3:0] ba[3], bb[3];
        logic [7:0] bexp[3];
        logic       bcar[3];
        int         blat[3];

        //          mul   op      a      b      data    carry
        vecs[0]  = '{1'b0, 3'b000, 4'd7,  4'd9,  8'h00, 1'b1};
        vecs[1]  = '{1'b0, 3'b000, 4'd3,  4'd4,  8'h07, 1'b0};
        vecs[2]  = '{1'b0, 3'b001, 4'd5,  4'd3,  8'h02, 1'b1};
        vecs[3]  = '{1'b0, 3'b010, 4'hC,  4'hA,  8'h08, 1'b0};
        vecs[4]  = '{1'b0, 3'b011, 4'hC,  4'h3,  8'h0F, 1'b0};
        vecs[5]  = '{1'b0, 3'b100, 4'hF,  4'h5,  8'h0A, 1'b0};
        vecs[6]  = '{1'b1, 3'b111, 4'd15, 4'd15, 8'hE1, 1'b0};
        vecs[7]  = '{1'b1, 3'b000, 4'd6,  4'd0,  8'h00, 1'b0};
        vecs[8]  = '{1'b1, 3'b000, 4'd1,  4'd13, 8'h0D, 1'b0};
        vecs[9]  = '{1'b1, 3'b000, 4'd0,  4'd9,  8'h00, 1'b0};
        vecs[10] = '{1'b1, 3'b000, 4'd12, 4'd11, 8'h84, 1'b0};
        vecs[11] = '{1'b1, 3'b000, 4'd7,  4'd8,  8'h38, 1'b0};

        // Reset held two cycles
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_alu_op",    o_alu_op, 0);
        chk("rst_alu_a",     o_alu_a, 0);
        chk("rst_alu_b",     o_alu_b, 0);
        chk("rst_rsp_data",  o_rsp_data, 0);
        chk("rst_rsp_carry", o_rsp_carry, 0);

        // Table-driven single ops and multiplies, rsp_ready held high
        i_rsp_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].mul, vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy", i), o_cmd_ready, 0);
            wait_rsp(edges, nbf);
            chk($sformatf("v%0d_latency", i), edges, vecs[i].mul ? 4 : 1);
            chk($sformatf("v%0d_data", i), o_rsp_data, vecs[i].data);
            chk($sformatf("v%0d_carry", i), o_rsp_carry, vecs[i].carry);
            if (vecs[i].mul && vecs[i].a == 4'hF && vecs[i].b == 4'hF)
                chk("mul15_adder_cycles", nbf, 4);
            @(posedge i_clk);
            #1;
            chk($sformatf("v%0d_valid_drop", i), o_rsp_valid, 0);
            chk($sformatf("v%0d_idle", i), o_cmd_ready, 1);
            chk($sformatf("v%0d_data_held", i), o_rsp_data, vecs[i].data);
        end

        // Backpressure: 3*5 held in DONE for 6 cycles, a command pulse is ignored
        i_rsp_ready = 1'b0;
        send(1'b1, 3'b000, 4'd3, 4'd5);
        wait_rsp(edges, nbf);
        chk("bp_latency", edges, 4);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bp%0d_valid", k), o_rsp_valid, 1);
            chk($sformatf("bp%0d_data", k), o_rsp_data, 8'h0F);
            chk($sformatf("bp%0d_carry", k), o_rsp_carry, 0);
            chk($sformatf("bp%0d_cmd_ready", k), o_cmd_ready, 0);
            @(negedge i_clk);
            i_cmd_mul = 1'b0; i_cmd_op = 3'b000; i_cmd_a = 4'd1; i_cmd_b = 4'd1;
            i_cmd_valid = (k == 2);
            @(posedge i_clk);
            #1;
        end
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("bp_release_valid", o_rsp_valid, 0);
        chk("bp_release_idle", o_cmd_ready, 1);
        seen = 0;
        repeat (4) begin
            @(posedge i_clk);
            #1;
            if (o_rsp_valid) seen++;
        end
        chk("bp_pulse_ignored", seen, 0);

        // Reset on the second MUL cycle of 9*11 aborts without a response
        send(1'b1, 3'b000, 4'd9, 4'd11);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        chk("abort_idle", o_cmd_ready, 1);
        chk("abort_valid", o_rsp_valid, 0);
        chk("abort_alu_a", o_alu_a, 0);
        chk("abort_alu_b", o_alu_b, 0);
        chk("abort_data", o_rsp_data, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge i_clk);
            #1;
            if (o_rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        send(1'b0, 3'b000, 4'd2, 4'd3);
        wait_rsp(edges, nbf);
        chk("post_abort_latency", edges, 1);
        chk("post_abort_data", o_rsp_data, 8'h05);
        chk("post_abort_carry", o_rsp_carry, 0);
        @(posedge i_clk);
        #1;

        // Back-to-back: cmd_valid held with three queued commands
        bmul[0] = 1'b0; bop[0] = 3'b000; ba[0] = 4'd8;  bb[0] = 4'd9;  bexp[0] = 8'h01; bcar[0] = 1'b1; blat[0] = 2;
        bmul[1] = 1'b1; bop[1] = 3'b000; ba[1] = 4'd13; bb[1] = 4'd14; bexp[1] = 8'hB6; bcar[1] = 1'b0; blat[1] = 5;
        bmul[2] = 1'b0; bop[2] = 3'b100; ba[2] = 4'd6;  bb[2] = 4'd3;  bexp[2] = 8'h05; bcar[2] = 1'b0; blat[2] = 2;
        idx = 0; got = 0; cyc = 0;
        @(negedge i_clk);
        i_cmd_mul = bmul[0]; i_cmd_op = bop[0]; i_cmd_a = ba[0]; i_cmd_b = bb[0];
        i_cmd_valid = 1'b1;
        while (got < 3 && cyc < 60) begin
            acc = o_cmd_ready && i_cmd_valid;
            @(posedge i_clk);
            if (acc) begin
                acc_c[idx] = cyc;
                idx++;
            end
            cyc++;
            #1;
            if (o_rsp_valid) begin
                chk($sformatf("b2b%0d_data", got), o_rsp_data, bexp[got]);
                chk($sformatf("b2b%0d_carry", got), o_rsp_carry, bcar[got]);
                chk($sformatf("b2b%0d_latency", got), cyc - acc_c[got], blat[got]);
                got++;
            end
            @(negedge i_clk);
            if (idx < 3) begin
                i_cmd_mul = bmul[idx]; i_cmd_op = bop[idx]; i_cmd_a = ba[idx]; i_cmd_b = bb[idx];
            end else begin
                i_cmd_valid = 1'b0;
            end
        end
        i_cmd_valid = 1'b0;
        chk("b2b_responses", got, 3);
        chk("b2b_spacing_single", acc_c[1] - acc_c[0], 3);
        chk("b2b_spacing_mul", acc_c[2] - acc_c[1], 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle controller in front of the 4-bit ALU datapath (operand preprocess plus adder).
- Accepts commands over a valid/ready handshake and drives the ALU Op/operand inputs.
- Captures the ALU result and carry, and returns a response over a second valid/ready handshake.
- Also sequences an unsigned WIDTH x WIDTH shift-add multiply by reusing the ALU adder (Op = OP_ADD) once per multiplier bit.

Parameters:
WIDTH, 4, operand/ALU datapath width; result width is 2*WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_mul  input  1  1 = multiply A*B, cmd_op ignored; 0 = single ALU op
cmd_op  input  3  ALU Op code for a single op
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
alu_op  output  3  Op driven to ALU
alu_a  output  WIDTH  A operand driven to ALU
alu_b  output  WIDTH  B operand driven to ALU
alu_r  input  WIDTH  ALU result (combinational from alu_op/a/b)
alu_c  input  1  ALU carry-out
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  2*WIDTH  result
rsp_carry  output  1  carry of single op; 0 for multiply

Behaviour:
- States: IDLE, EXEC, MUL, DONE.
- Reset: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0, alu_op=3'b000, alu_a=0, alu_b=0, counter=0, internal registers cleared.
- Reset asserted mid-operation: abort to IDLE next edge; the in-flight command is discarded and produces no response.
- cmd_ready = 1 only in IDLE (combinational from state).
- A command is accepted on a cycle with cmd_valid & cmd_ready. Operands and op are latched on that cycle.
- Accept with cmd_mul=0 -> EXEC. Accept with cmd_mul=1 -> MUL.
- EXEC (1 cycle):
  - Drive alu_op=latched op, alu_a=A, alu_b=B.
  - At end of cycle register rsp_data={WIDTH'b0, alu_r} and rsp_carry=alu_c, then go to DONE.
  - Latency: accept at cycle 0, rsp_valid=1 at cycle 2.
- MUL: registers acc (WIDTH), mq (WIDTH, holds multiplier B), md (multiplicand A), and a counter of width clog2(WIDTH+1).
  - On accept: acc=0, mq=B, md=A, counter=0.
  - Each MUL cycle drive alu_op=OP_ADD, alu_a=acc, alu_b = mq[0] ? md : 0.
  - At end of each cycle: {acc, mq} = {alu_c, alu_r, mq} >> 1, i.e. acc={alu_c, alu_r[WIDTH-1:1]}, mq={alu_r[0], mq[WIDTH-1:1]}; counter++.
  - After exactly WIDTH MUL cycles register rsp_data={acc,mq} (updated values) and rsp_carry=0, then go to DONE.
  - Latency: accept at cycle 0, rsp_valid=1 at cycle WIDTH+1.
- Outside EXEC/MUL: alu_op=3'b000, alu_a=0, alu_b=0. This holds the ALU inputs quiet.
- DONE: rsp_valid=1; rsp_data and rsp_carry held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready -> IDLE; rsp_valid drops next cycle and rsp_data keeps its last value.
  - No new command is accepted in the same cycle as the response handshake; minimum command spacing is 3 cycles for a single op and WIDTH+2 cycles for a multiply.
- Arithmetic is unsigned; the product always fits in 2*WIDTH bits and never overflows.
- Boundaries:
  - A=0 or B=0 gives 0.
  - 15*15 gives 8'hE1 (WIDTH=4).
  - The carry from the adder is folded into acc every iteration and never lost.

Decomposition:
- Shared package alu_pkg holds:
  - the state enum (IDLE, EXEC, MUL, DONE);
  - localparam OP_ADD = 3'b000, the ALU Op for A+B passthrough;
  - the Op code width (3).
- The ALU Op encodings used elsewhere in the ALU also belong in alu_pkg.
- No sub-module is required. The iteration counter is a few lines inline.
- The preprocess/ALU instance stays outside this block. The top level wires alu_* ports to it.

Test Plan:
- Reset held 2 cycles, then released -> cmd_ready=1, rsp_valid=0, alu_op=0, alu_a=0, alu_b=0, rsp_data=0.
- Single op cmd_op=000, A=7, B=9 (bench ALU model adds), rsp_ready=1 -> rsp_valid at cycle 2 with rsp_data=8'h00, rsp_carry=1; then back to IDLE.
- Multiply A=15, B=15 -> alu_op=000 for exactly 4 cycles, rsp_valid at cycle 5, rsp_data=8'hE1, rsp_carry=0. Also A=6, B=0 -> 8'h00, and A=1, B=13 -> 8'h0D.
- Backpressure: multiply 3*5 with rsp_ready=0 for 6 cycles -> rsp_valid and rsp_data=8'h0F stable throughout and cmd_ready=0; a cmd_valid pulse during this window is not accepted.
- Reset pulsed on the 2nd MUL cycle of 9*11 -> IDLE next cycle, no rsp_valid ever produced. A following single op still completes with correct latency.
- Back-to-back: cmd_valid held high with 3 queued commands and rsp_ready=1 -> each accepted only in IDLE, responses returned in order with the exact latencies above.
